// File: rtl/softermax_pkg.sv
// Shared sizing defaults, vector types and scheduler state encoding for the
// softermax scheduler.
package softermax_pkg;

   localparam int SM_NREQ       = 4;
   localparam int SM_VEC_SIZE   = 10;
   localparam int SM_BW         = 8;
   localparam int SM_OUT_W      = 32;
   localparam int SM_DP_LAT     = 3;
   localparam int SM_FIFO_DEPTH = 4;
   localparam int ID_W          = $clog2(SM_NREQ);

   typedef logic [SM_VEC_SIZE-1:0][SM_BW-1:0]    sm_in_vec_t;
   typedef logic [SM_VEC_SIZE-1:0][SM_OUT_W-1:0] sm_out_vec_t;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      IDLE  = 2'd2
   } sched_state_e;

endpackage

// File: rtl/softermax_rr_arb.sv
// Round-robin arbiter: the first requester at or after the pointer wins, and
// the pointer moves just past the winner on every grant.
module softermax_rr_arb
   import softermax_pkg::*;
#(
   parameter int  NREQ = SM_NREQ,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_en,
   input  logic [NREQ-1:0] i_req,
   output logic [NREQ-1:0] o_gnt,
   output logic [IDW-1:0]  o_gnt_id,
   output logic            o_gnt_vld
);

   logic [IDW-1:0] r_ptr;

   always_comb begin : p_arb
      int v_idx;
      v_idx     = 0;
      o_gnt     = '0;
      o_gnt_id  = '0;
      o_gnt_vld = 1'b0;
      if (i_en) begin
         for (int k = 0; k < NREQ; k++) begin
            v_idx = int'(r_ptr) + k;
            if (v_idx >= NREQ) v_idx = v_idx - NREQ;
            if (!o_gnt_vld && i_req[v_idx]) begin
               o_gnt_vld    = 1'b1;
               o_gnt_id     = IDW'(v_idx);
               o_gnt[v_idx] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ptr <= '0;
      end else if (o_gnt_vld) begin
         r_ptr <= (o_gnt_id == IDW'(NREQ - 1)) ? '0 : o_gnt_id + IDW'(1);
      end
   end

endmodule

// File: rtl/softermax_sched.sv
// Shares one fixed-latency softermax datapath between NREQ requesters, tags
// each issued vector with its requester ID and buffers results in a FIFO.
module softermax_sched
   import softermax_pkg::*;
#(
   parameter int  NREQ       = SM_NREQ,
   parameter int  VEC_SIZE   = SM_VEC_SIZE,
   parameter int  BW         = SM_BW,
   parameter int  OUT_W      = SM_OUT_W,
   parameter int  DP_LAT     = SM_DP_LAT,
   parameter int  FIFO_DEPTH = SM_FIFO_DEPTH,
   localparam int TAG_W      = $clog2(NREQ),
   localparam int VB         = VEC_SIZE * BW,
   localparam int VO         = VEC_SIZE * OUT_W
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [NREQ-1:0]    i_req_valid,
   output logic [NREQ-1:0]    o_req_ready,
   input  logic [NREQ*VB-1:0] i_req_vec,
   input  logic               i_flush,
   output logic               o_idle,
   output logic [VB-1:0]      o_dp_in,
   input  logic [VO-1:0]      i_dp_out,
   output logic               o_out_valid,
   input  logic               i_out_ready,
   output logic [TAG_W-1:0]   o_out_id,
   output logic [VO-1:0]      o_out_vec
);

   localparam int ENTRY_W = TAG_W + VO;
   localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
   localparam int OCC_W   = $clog2(DP_LAT + FIFO_DEPTH + 1);

   function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   sched_state_e       r_state;
   logic [DP_LAT-1:0]  r_tag_vld_p;
   logic [TAG_W-1:0]   r_tag_id_p [DP_LAT];
   logic [ENTRY_W-1:0] r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [CNT_W-1:0]   r_count;

   logic [NREQ-1:0]    w_gnt;
   logic [TAG_W-1:0]   w_gnt_id;
   logic               w_gnt_vld;
   logic               w_arb_en;
   logic [OCC_W-1:0]   w_inflight;
   logic [OCC_W-1:0]   w_occ;
   logic               w_push;
   logic               w_pop;
   logic               w_fifo_empty;
   logic [ENTRY_W-1:0] w_head;

   assign w_fifo_empty = (r_count == '0);
   assign o_out_valid  = !w_fifo_empty;
   assign w_pop        = o_out_valid & i_out_ready;
   assign w_push       = r_tag_vld_p[DP_LAT-1];

   // Credit: every vector in the pipe already owns a FIFO slot, so the
   // datapath never has to stall; a same-cycle pop frees one slot early.
   always_comb begin
      w_inflight = '0;
      for (int s = 0; s < DP_LAT; s++) begin
         w_inflight = w_inflight + OCC_W'(r_tag_vld_p[s]);
      end
      w_occ    = w_inflight + OCC_W'(r_count) - OCC_W'(w_pop);
      w_arb_en = (r_state == RUN) && !i_flush && !i_rst &&
                 (w_occ < OCC_W'(FIFO_DEPTH));
   end

   softermax_rr_arb #(
      .NREQ (NREQ)
   ) u_arb (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_en      (w_arb_en),
      .i_req     (i_req_valid),
      .o_gnt     (w_gnt),
      .o_gnt_id  (w_gnt_id),
      .o_gnt_vld (w_gnt_vld)
   );

   assign o_req_ready = w_gnt;

   always_comb begin
      o_dp_in = '0;
      if (w_gnt_vld) o_dp_in = i_req_vec[int'(w_gnt_id)*VB +: VB];
   end

   // Stage p0..p(DP_LAT-1): tag pipe tracking the datapath contents
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_tag_vld_p <= '0;
      end else begin
         r_tag_vld_p[0] <= w_gnt_vld;
         for (int s = 1; s < DP_LAT; s++) r_tag_vld_p[s] <= r_tag_vld_p[s-1];
      end
   end

   always_ff @(posedge i_clk) begin
      r_tag_id_p[0] <= w_gnt_id;
      for (int s = 1; s < DP_LAT; s++) r_tag_id_p[s] <= r_tag_id_p[s-1];
   end

   // Result FIFO: captures dp_out on the edge its tag leaves the last stage
   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= {r_tag_id_p[DP_LAT-1], i_dp_out};
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= f_ptr_inc(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= f_ptr_inc(r_rd_ptr);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign w_head    = r_mem[r_rd_ptr];
   assign o_out_id  = o_out_valid ? w_head[ENTRY_W-1 -: TAG_W] : '0;
   assign o_out_vec = o_out_valid ? w_head[VO-1:0] : '0;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= RUN;
      end else begin
         case (r_state)
            RUN:     if (i_flush) r_state <= DRAIN;
            DRAIN:   if ((w_inflight == '0) && w_fifo_empty) r_state <= IDLE;
            IDLE:    if (!i_flush) r_state <= RUN;
            default: r_state <= RUN;
         endcase
      end
   end

   assign o_idle = i_rst || (r_state == IDLE) ||
                   ((r_state == RUN) && (w_inflight == '0) && w_fifo_empty &&
                    !(|i_req_valid));

   overflow_a : assert property (@(posedge i_clk) disable iff (i_rst)
      !(w_push && !w_pop && (r_count == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_softermax_sched.sv
// Bench for softermax_sched: a behavioural softermax datapath stub with fixed
// latency, plus a scoreboard of expected {id, result} in grant order.
module tb_softermax_sched;

   localparam int NREQ = 4, VEC_SIZE = 10, BW = 8, OUT_W = 32;
   localparam int DP_LAT = 3, FIFO_DEPTH = 4, IDW = 2;
   localparam int VB = VEC_SIZE * BW, VO = VEC_SIZE * OUT_W;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [NREQ-1:0]    req_valid = '0;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ*VB-1:0] req_vec = '0;
   logic               flush = 1'b0;
   logic               idle;
   logic [VB-1:0]      dp_in;
   logic [VO-1:0]      dp_out;
   logic               out_valid;
   logic               out_ready = 1'b1;
   logic [IDW-1:0]     out_id;
   logic [VO-1:0]      out_vec;

   typedef struct packed {
      logic [IDW-1:0] id;
      logic [VO-1:0]  vec;
   } exp_t;

   exp_t          sb[$];
   exp_t          sb_head;
   int            n_checks = 0;
   int            n_errors = 0;
   int            exp_ptr  = 0;
   int            seq      = 0;
   logic [VO-1:0] dp_pipe [DP_LAT];

   softermax_sched #(
      .NREQ(NREQ), .VEC_SIZE(VEC_SIZE), .BW(BW), .OUT_W(OUT_W),
      .DP_LAT(DP_LAT), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_vec(req_vec), .i_flush(flush), .o_idle(idle), .o_dp_in(dp_in),
      .i_dp_out(dp_out), .o_out_valid(out_valid), .i_out_ready(out_ready),
      .o_out_id(out_id), .o_out_vec(out_vec)
   );

   always #5 clk = ~clk;

   // Base-2 softermax on signed integer inputs, result in Q.16
   function automatic logic [VO-1:0] f_soft(input logic [VB-1:0] v);
      logic [VO-1:0] r;
      int            x [VEC_SIZE];
      int            m, d;
      longint        e [VEC_SIZE];
      longint        s;
      r = '0; m = -1000; s = 0;
      for (int k = 0; k < VEC_SIZE; k++) begin
         x[k] = int'($signed(v[k*BW +: BW]));
         if (x[k] > m) m = x[k];
      end
      for (int k = 0; k < VEC_SIZE; k++) begin
         d    = m - x[k];
         e[k] = (d >= 31) ? 64'sd0 : (longint'(1) << (31 - d));
         s    = s + e[k];
      end
      for (int k = 0; k < VEC_SIZE; k++) r[k*OUT_W +: OUT_W] = OUT_W'((e[k] << 16) / s);
      return r;
   endfunction

   function automatic logic [VB-1:0] mk_vec(input int r, input int n);
      logic [VB-1:0] v;
      for (int k = 0; k < VEC_SIZE; k++) v[k*BW +: BW] = BW'((k * (r + 1) + n) % 24);
      return v;
   endfunction

   task automatic refresh_vecs();
      seq++;
      for (int r = 0; r < NREQ; r++) req_vec[r*VB +: VB] = mk_vec(r, seq + 3 * r);
   endtask

   // Datapath stub: not reset, so stale contents survive a scheduler reset
   always @(posedge clk) begin
      dp_pipe[0] <= f_soft(dp_in);
      for (int s = 1; s < DP_LAT; s++) dp_pipe[s] <= dp_pipe[s-1];
   end
   assign dp_out = dp_pipe[DP_LAT-1];

   // Scoreboard: push on every observed grant, pop/compare on every transfer out
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && out_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_errors++;
               $display("FAIL unexpected_output: got id=%0d vec=%h, required no output", out_id, out_vec);
            end else begin
               sb_head = sb.pop_front();
               if (out_id !== sb_head.id || out_vec !== sb_head.vec) begin
                  n_errors++;
                  $display("FAIL out_data: got id=%0d vec=%h, required id=%0d vec=%h",
                           out_id, out_vec, sb_head.id, sb_head.vec);
               end
            end
         end
         for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) sb.push_back({IDW'(i), f_soft(req_vec[i*VB +: VB])});
         end
      end
   end

   task automatic wait_drain(input string name);
      bit done = 1'b0;
      for (int c = 0; c < 60 && !done; c++) begin
         @(negedge clk);
         if (sb.size() == 0 && idle) done = 1'b1;
      end
      n_checks++;
      if (!done) begin
         n_errors++;
         $display("FAIL %s_drain: got pending=%0d idle=%0b, required pending=0 idle=1", name, sb.size(), idle);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = '1; out_ready = 1'b1; refresh_vecs();
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         n_checks++;
         if (req_ready !== '0 || out_valid !== 1'b0 || idle !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_ctrl: got ready=%b out_valid=%b idle=%b, required 0000/0/1", req_ready, out_valid, idle);
         end
         n_checks++;
         if (out_id !== '0 || out_vec !== '0 || dp_in !== '0) begin
            n_errors++;
            $display("FAIL reset_data: got id=%0d vec=%h dp_in=%h, required all zero", out_id, out_vec, dp_in);
         end
      end
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (req_ready !== 4'b0001) begin
         n_errors++;
         $display("FAIL reset_first_grant: got %b, required 0001", req_ready);
      end
      exp_ptr = 1;
      @(posedge clk); #1; req_valid = '0;
      wait_drain("reset");
   endtask

   task automatic test_single();
      logic [VB-1:0] fours;
      @(posedge clk); #1;
      for (int k = 0; k < VEC_SIZE; k++) fours[k*BW +: BW] = 8'h04;
      req_vec[2*VB +: VB] = fours;
      req_valid = 4'b0100;
      @(negedge clk);
      n_checks++;
      if (req_ready !== 4'b0100 || dp_in !== fours) begin
         n_errors++;
         $display("FAIL single_grant: got ready=%b dp_in=%h, required 0100 dp_in=%h", req_ready, dp_in, fours);
      end
      exp_ptr = 3;
      @(posedge clk); #1; req_valid = '0;
      for (int e = 1; e <= 4; e++) begin
         if (e > 1) @(posedge clk);
         @(negedge clk);
         n_checks++;
         if (e < 4 && (out_valid !== 1'b0 || req_ready !== '0)) begin
            n_errors++;
            $display("FAIL single_latency: edge %0d got out_valid=%b ready=%b, required 0/0000", e, out_valid, req_ready);
         end
         if (e == 4 && (out_valid !== 1'b1 || out_id !== 2'd2 || out_vec[OUT_W-1:0] !== 32'd6553)) begin
            n_errors++;
            $display("FAIL single_result: got valid=%b id=%0d elem0=%0d, required 1/2/6553",
                     out_valid, out_id, out_vec[OUT_W-1:0]);
         end
      end
      wait_drain("single");
   endtask

   task automatic grant_check(input string name);
      logic [NREQ-1:0] exp_gnt;
      if (|req_ready) begin
         exp_gnt = NREQ'(1) << exp_ptr;
         n_checks++;
         if (req_ready !== exp_gnt) begin
            n_errors++;
            $display("FAIL %s_grant: got %b, required %b", name, req_ready, exp_gnt);
         end
         exp_ptr = (exp_ptr + 1) % NREQ;
      end
   endtask

   task automatic test_fairness();
      @(posedge clk); #1; req_valid = '1; out_ready = 1'b1; refresh_vecs();
      for (int n = 0; n < 16; n++) begin
         @(negedge clk);
         n_checks++;
         if (req_ready !== (NREQ'(1) << exp_ptr)) begin
            n_errors++;
            $display("FAIL fair_grant: cycle %0d got %b, required %b", n, req_ready, NREQ'(1) << exp_ptr);
         end
         exp_ptr = (exp_ptr + 1) % NREQ;
         if (n >= 4) begin
            n_checks++;
            if (out_valid !== 1'b1) begin
               n_errors++;
               $display("FAIL fair_bubble: cycle %0d got out_valid=%b, required 1", n, out_valid);
            end
         end
         @(posedge clk); #1; refresh_vecs();
      end
      req_valid = '0;
      wait_drain("fair");
   endtask

   task automatic test_backpressure();
      int             grants = 0;
      logic [IDW-1:0] hold_id = '0;
      logic [VO-1:0]  hold_vec = '0;
      @(posedge clk); #1; out_ready = 1'b0; req_valid = '1; refresh_vecs();
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (|req_ready) grants++;
         grant_check("bp");
         if (c == 5) begin hold_id = out_id; hold_vec = out_vec; end
         @(posedge clk); #1; refresh_vecs();
      end
      @(negedge clk);
      n_checks++;
      if (grants != FIFO_DEPTH || req_ready !== '0) begin
         n_errors++;
         $display("FAIL bp_credit: got grants=%0d ready=%b, required %0d/0000", grants, req_ready, FIFO_DEPTH);
      end
      n_checks++;
      if (out_valid !== 1'b1 || out_id !== hold_id || out_vec !== hold_vec) begin
         n_errors++;
         $display("FAIL bp_hold: got valid=%b id=%0d, required 1 id=%0d with unchanged vector", out_valid, out_id, hold_id);
      end
      @(posedge clk); #1; out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         grant_check("bp_resume");
         @(posedge clk); #1; refresh_vecs();
      end
      req_valid = '0;
      wait_drain("bp");
   endtask

   task automatic test_flush();
      bit done = 1'b0;
      @(posedge clk); #1; req_valid = '1; out_ready = 1'b1; refresh_vecs();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         grant_check("flush_pre");
         @(posedge clk); #1; refresh_vecs();
      end
      flush = 1'b1;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         n_checks++;
         if (req_ready !== '0) begin
            n_errors++;
            $display("FAIL flush_nogrant: got %b, required 0000", req_ready);
         end
         if (idle && sb.size() == 0) done = 1'b1;
      end
      n_checks++;
      if (!done) begin
         n_errors++;
         $display("FAIL flush_idle: got idle=%b pending=%0d, required 1/0", idle, sb.size());
      end
      @(posedge clk); #1; flush = 1'b0;
      @(negedge clk);
      n_checks++;
      if (req_ready !== '0) begin
         n_errors++;
         $display("FAIL flush_exit: got %b, required 0000", req_ready);
      end
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if (req_ready !== (NREQ'(1) << exp_ptr)) begin
         n_errors++;
         $display("FAIL flush_resume: got %b, required %b", req_ready, NREQ'(1) << exp_ptr);
      end
      exp_ptr = (exp_ptr + 1) % NREQ;
      @(posedge clk); #1; req_valid = '0;
      wait_drain("flush");
   endtask

   task automatic test_reset_midop();
      @(posedge clk); #1; req_valid = '1; out_ready = 1'b1; refresh_vecs();
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         grant_check("midop_pre");
         @(posedge clk); #1; refresh_vecs();
      end
      rst = 1'b1; req_valid = '0;
      sb.delete();
      @(posedge clk); #1; rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         n_checks++;
         if (out_valid !== 1'b0 || idle !== 1'b1) begin
            n_errors++;
            $display("FAIL midop_stale: cycle %0d got out_valid=%b idle=%b, required 0/1", c, out_valid, idle);
         end
      end
      @(posedge clk); #1; req_valid = 4'b1010; refresh_vecs();
      @(negedge clk);
      n_checks++;
      if (req_ready !== 4'b0010) begin
         n_errors++;
         $display("FAIL midop_ptr: got %b, required 0010", req_ready);
      end
      @(posedge clk); #1; req_valid = '0;
      wait_drain("midop");
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_backpressure();
      test_flush();
      test_reset_midop();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
